// File: rtl/mem_arbiter.sv
// Block-transfer arbiter sharing one word-addressed memory between the L1 I-cache and D-cache.
// Round-robin grant, fixed first-word latency, then one block word per cycle.
module mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int MEM_LATENCY = 3,
  parameter int BEAT_W      = $clog2(BLOCK_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [BEAT_W-1:0] beat,
  output logic [31:0]       rdata,
  output logic              rvalid_i,
  output logic              rvalid_d,
  output logic              busy,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int                CNT_W      = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BLOCK_WORDS - 1);
  localparam logic [31:0]       ALIGN_MASK = ~(32'(BLOCK_WORDS - 1));

  logic [1:0]        state;
  logic              owner;
  logic              we;
  logic [31:0]       base;
  logic [CNT_W-1:0]  cnt;
  logic [BEAT_W-1:0] beat_q;
  logic              last_grant;

  logic grant_d;
  logic grant_any;

  // Handshake: a requester raises *_req and holds it; the arbiter samples
  // requests only in IDLE, and *_ack pulses for exactly one cycle when the
  // whole block has moved. Dropping req after grant does not cancel anything.
  always_comb begin
    grant_d = 1'b0;
    if (i_req && d_req) grant_d = (last_grant == OWN_I);
    else                grant_d = d_req;
  end

  assign grant_any = i_req | d_req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      owner      <= OWN_I;
      we         <= 1'b0;
      base       <= '0;
      cnt        <= '0;
      beat_q     <= '0;
      last_grant <= OWN_I;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            state      <= S_WAIT;
            owner      <= grant_d;
            we         <= grant_d & d_we;
            base       <= (grant_d ? d_addr : i_addr) & ALIGN_MASK;
            cnt        <= CNT_LOAD;
            last_grant <= grant_d;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state  <= S_XFER;
            beat_q <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_XFER: begin
          if (beat_q == BEAT_LAST) begin
            state  <= S_DONE;
            beat_q <= '0;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath is gated to zero outside XFER so idle cycles present a clean bus.
  always_comb begin
    beat     = '0;
    mem_addr = '0;
    mem_din  = '0;
    rdata    = '0;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    rvalid_i = 1'b0;
    rvalid_d = 1'b0;
    if (state == S_XFER) begin
      beat     = beat_q;
      mem_addr = base + 32'(beat_q);
      if (we) begin
        mem_wen = 1'b1;
        mem_din = d_wdata;
      end else begin
        mem_ren  = 1'b1;
        rdata    = mem_dout;
        rvalid_i = (owner == OWN_I);
        rvalid_d = (owner == OWN_D);
      end
    end
  end

  assign i_ack     = (state == S_DONE) && (owner == OWN_I);
  assign d_ack     = (state == S_DONE) && (owner == OWN_D);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
